timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl_pkg.sv | 18 +
 rtl/timer_ctrl_prescaler.sv | 43 ++++
 rtl/timer_ctrl.sv | 155 +++++++++++++++
 tb/tb_timer_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg
// Shared definitions for the timer controller: the controller state type,
// the smallest divisor the prescaler can honour and the divisor loaded at
// reset (1 Hz clk_out from a 40 kHz system clock).
package timer_ctrl_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // A divisor of 0 or 1 cannot produce a registered one-cycle tick
   // followed by a low cycle, so smaller requests are raised to this.
   localparam int MIN_DIV = 2;

   localparam int DEFAULT_DIV = 20_000;

endpackage

// File: rtl/timer_ctrl_prescaler.sv
// tick_prescaler
// Free-running cycle counter that wraps at div-1 while enabled.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   en    - count this cycle
//   clr   - force the counter back to 0 (wins over en)
//   div   - cycles per wrap, assumed >= 2
//   wrap  - high in the cycle the counter sits at div-1 while enabled;
//           the counter returns to 0 on the following edge
module tick_prescaler #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] div,
   output logic             wrap
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      wrap  = en && (cnt_q == (div - WIDTH'(1)));
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = wrap ? '0 : (cnt_q + WIDTH'(1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl
// Programmable tick timer. A configuration (divisor, tick count, periodic
// flag) is latched while idle; start then runs for count ticks, one tick
// every div cycles, optionally reloading forever.
// Ports:
//   clk, rst_n           - clock (rising edge), async active-low reset
//   cfg_valid/cfg_ready  - configuration handshake, ready only while idle
//   cfg_div              - clk cycles per tick
//   cfg_count            - ticks per run (0 makes start a no-op)
//   cfg_periodic         - reload and rerun when a run completes
//   start, stop          - run request / abort request
//   tick                 - registered one-cycle pulse per divided period
//   done                 - registered pulse on the final tick of a run
//   busy                 - high while running
//   remaining            - ticks left in the current run
//   clk_out              - toggles on every tick
module timer_ctrl #(
   parameter int WIDTH       = 16,
   parameter int CNT_W       = 8,
   parameter int DEFAULT_DIV = timer_ctrl_pkg::DEFAULT_DIV
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_div,
   input  logic [CNT_W-1:0] cfg_count,
   input  logic             cfg_periodic,
   input  logic             start,
   input  logic             stop,
   output logic             tick,
   output logic             done,
   output logic             busy,
   output logic [CNT_W-1:0] remaining,
   output logic             clk_out
);

   import timer_ctrl_pkg::*;

   state_e           state_q,     state_d;
   logic [WIDTH-1:0] div_q,       div_d;
   logic [CNT_W-1:0] count_q,     count_d;
   logic             periodic_q,  periodic_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic             clk_out_q,   clk_out_d;
   logic             tick_q,      tick_d;
   logic             done_q,      done_d;

   logic             cfg_accept;
   logic             pre_en;
   logic             pre_clr;
   logic             wrap;

   // The prescaler is held at 0 whenever idle so a start always begins a
   // full period; a stop also clears it so nothing carries into the next run.
   assign pre_en  = (state_q == ST_RUN);
   assign pre_clr = (state_q == ST_IDLE) || stop;

   tick_prescaler #(
      .WIDTH(WIDTH)
   ) u_prescaler (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (pre_en),
      .clr  (pre_clr),
      .div  (div_q),
      .wrap (wrap)
   );

   assign cfg_ready  = (state_q == ST_IDLE);
   assign cfg_accept = cfg_valid && cfg_ready;

   // Next-state logic. A start in the same cycle as a config accept sees the
   // freshly accepted values through count_d/div_d. The completion action
   // (reload or return to idle) happens in the cycle done is visible; with
   // div >= 2 that cycle can never coincide with another wrap.
   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      count_d     = count_q;
      periodic_d  = periodic_q;
      remaining_d = remaining_q;
      clk_out_d   = clk_out_q;
      tick_d      = 1'b0;
      done_d      = 1'b0;

      if (cfg_accept) begin
         div_d      = (cfg_div < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : cfg_div;
         count_d    = cfg_count;
         periodic_d = cfg_periodic;
      end

      case (state_q)
         ST_IDLE: begin
            if (start && (count_d != '0)) begin
               state_d     = ST_RUN;
               remaining_d = count_d;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else begin
               if (done_q) begin
                  if (periodic_q) begin
                     remaining_d = count_q;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
               if (wrap) begin
                  tick_d      = 1'b1;
                  done_d      = (remaining_q == CNT_W'(1));
                  remaining_d = remaining_q - CNT_W'(1);
                  clk_out_d   = ~clk_out_q;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and configuration registers; reset leaves a 1 Hz free-running
   // configuration latched so a bare start produces the default clk_out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         div_q       <= WIDTH'(DEFAULT_DIV);
         count_q     <= CNT_W'(1);
         periodic_q  <= 1'b1;
         remaining_q <= '0;
         clk_out_q   <= 1'b0;
         tick_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         count_q     <= count_d;
         periodic_q  <= periodic_d;
         remaining_q <= remaining_d;
         clk_out_q   <= clk_out_d;
         tick_q      <= tick_d;
         done_q      <= done_d;
      end
   end

   assign busy      = (state_q == ST_RUN);
   assign tick      = tick_q;
   assign done      = done_q;
   assign remaining = remaining_q;
   assign clk_out   = clk_out_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl
// Self-checking bench for timer_ctrl: a table of directed vectors, a few
// hand-written multi-cycle sequences, and a randomized run compared against
// an elapsed-time model of the timer.
module tb_timer_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [15:0] cfg_div;
   logic [7:0]  cfg_count;
   logic        cfg_periodic;
   logic        start;
   logic        stop;
   logic        tick;
   logic        done;
   logic        busy;
   logic [7:0]  remaining;
   logic        clk_out;

   int checks   = 0;
   int failures = 0;

   timer_ctrl #(
      .WIDTH(16),
      .CNT_W(8),
      .DEFAULT_DIV(20000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_div     (cfg_div),
      .cfg_count   (cfg_count),
      .cfg_periodic(cfg_periodic),
      .start       (start),
      .stop        (stop),
      .tick        (tick),
      .done        (done),
      .busy        (busy),
      .remaining   (remaining),
      .clk_out     (clk_out)
   );

   always #5 clk = ~clk;

   // Directed vector record: inputs held for reps cycles, outputs expected
   // after each of those edges.
   typedef struct {
      string       name;
      logic        cv;
      logic [15:0] div;
      logic [7:0]  cnt;
      logic        per;
      logic        st;
      logic        sp;
      logic        eTick;
      logic        eDone;
      logic        eBusy;
      logic [7:0]  eRem;
      logic        eClk;
      int          reps;
   } vec_t;

   vec_t vecs[$];

   task automatic addVec(input string name, input logic cv, input logic [15:0] d,
                         input logic [7:0] c, input logic p, input logic st, input logic sp,
                         input logic eT, input logic eD, input logic eB,
                         input logic [7:0] eR, input logic eC, input int reps);
      vec_t v;
      v.name = name; v.cv = cv; v.div = d; v.cnt = c; v.per = p; v.st = st; v.sp = sp;
      v.eTick = eT; v.eDone = eD; v.eBusy = eB; v.eRem = eR; v.eClk = eC; v.reps = reps;
      vecs.push_back(v);
   endtask

   // Drive inputs away from the active edge, then sample 1 time unit after it.
   task automatic applyStimulus(input logic cv, input logic [15:0] d, input logic [7:0] c,
                                input logic p, input logic st, input logic sp);
      @(negedge clk);
      cfg_valid    = cv;
      cfg_div      = d;
      cfg_count    = c;
      cfg_periodic = p;
      start        = st;
      stop         = sp;
      @(posedge clk);
      #1;
   endtask

   // cfg_ready is always expected to be the inverse of busy.
   task automatic checkOutput(input string name, input logic eT, input logic eD,
                              input logic eB, input logic [7:0] eR, input logic eC);
      checks++;
      if (tick !== eT || done !== eD || busy !== eB || cfg_ready !== !eB ||
          remaining !== eR || clk_out !== eC) begin
         failures++;
         $display("[TB] FAIL %s @%0t: got tick=%b done=%b busy=%b ready=%b rem=%0d clk_out=%b, expected tick=%b done=%b busy=%b ready=%b rem=%0d clk_out=%b",
                  name, $time, tick, done, busy, cfg_ready, remaining, clk_out,
                  eT, eD, eB, !eB, eR, eC);
      end
   endtask

   // Reference model: while running, everything follows from the number of
   // cycles elapsed since the start edge (e). Ticks fall on multiples of div,
   // the n-th tick ends a run when n is a multiple of count, and clk_out is
   // the starting level flipped once per tick.
   bit mRun;
   int mE;
   int mDiv;
   int mCnt;
   bit mPer;
   int mRemHold;
   bit mClkHold;
   bit mClkBase;

   task automatic modelReset();
      mRun = 0; mE = 0; mDiv = 20000; mCnt = 1; mPer = 1;
      mRemHold = 0; mClkHold = 0; mClkBase = 0;
   endtask

   task automatic modelExpect(output bit eT, output bit eD, output bit eB,
                              output int eR, output bit eC);
      int n;
      if (mRun) begin
         n  = mE / mDiv;
         eT = (mE > 0) && (mE % mDiv == 0);
         eD = eT && (n % mCnt == 0);
         eB = 1;
         eR = eD ? 0 : (mCnt - (n % mCnt));
         eC = mClkBase ^ bit'(n % 2);
      end else begin
         eT = 0; eD = 0; eB = 0; eR = mRemHold; eC = mClkHold;
      end
   endtask

   task automatic modelStep(input bit cv, input int d, input int c, input bit p,
                            input bit st, input bit sp);
      bit t, dn, b, ck;
      int r;
      if (!mRun) begin
         if (cv) begin
            mDiv = (d < 2) ? 2 : d;
            mCnt = c;
            mPer = p;
         end
         if (st && mCnt != 0) begin
            mRun = 1; mE = 0; mClkBase = mClkHold;
         end
      end else begin
         modelExpect(t, dn, b, r, ck);
         if (sp) begin
            mRun = 0; mRemHold = r; mClkHold = ck;
         end else if (!mPer && dn) begin
            mRun = 0; mRemHold = 0; mClkHold = ck;
         end else begin
            mE++;
         end
      end
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      cfg_valid = 0; cfg_div = '0; cfg_count = '0; cfg_periodic = 0; start = 0; stop = 0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset state", 0, 0, 0, 8'd0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
   endtask

   initial begin
      int lastRise;
      int rises;
      bit prevClk;
      int stray;
      bit mt, md, mb, mc;
      int mr;
      bit rcv, rp, rst, rsp;
      int rd, rc;

      // Directed table, starting from the reset configuration.
      addVec("cfg+start div4",   1, 16'd4, 8'd3, 0, 1, 0,  0, 0, 1, 8'd3, 0, 1);
      addVec("div4 pre tick1",   0, 16'd0, 8'd0, 0, 0, 0,  0, 0, 1, 8'd3, 0, 3);
      addVec("div4 tick1",       0, 16'd0, 8'd0, 0, 0, 0,  1, 0, 1, 8'd2, 1, 1);
      addVec("div4 pre tick2",   0, 16'd0, 8'd0, 0, 0, 0,  0, 0, 1, 8'd2, 1, 3);
      addVec("div4 tick2",       0, 16'd0, 8'd0, 0, 0, 0,  1, 0, 1, 8'd1, 0, 1);
      addVec("div4 pre tick3",   0, 16'd0, 8'd0, 0, 0, 0,  0, 0, 1, 8'd1, 0, 3);
      addVec("div4 final tick",  0, 16'd0, 8'd0, 0, 0, 0,  1, 1, 1, 8'd0, 1, 1);
      addVec("div4 back idle",   0, 16'd0, 8'd0, 0, 0, 0,  0, 0, 0, 8'd0, 1, 2);
      addVec("count0 cfg+start", 1, 16'd0, 8'd0, 0, 1, 0,  0, 0, 0, 8'd0, 1, 1);
      addVec("count0 start",     0, 16'd0, 8'd0, 0, 1, 0,  0, 0, 0, 8'd0, 1, 2);
      addVec("div0 cfg+start",   1, 16'd0, 8'd2, 0, 1, 0,  0, 0, 1, 8'd2, 1, 1);
      addVec("div0 e1",          0, 16'd0, 8'd0, 0, 0, 0,  0, 0, 1, 8'd2, 1, 1);
      addVec("div0 tick1",       0, 16'd0, 8'd0, 0, 0, 0,  1, 0, 1, 8'd1, 0, 1);
      addVec("div0 e3",          0, 16'd0, 8'd0, 0, 0, 0,  0, 0, 1, 8'd1, 0, 1);
      addVec("div0 final tick",  0, 16'd0, 8'd0, 0, 0, 0,  1, 1, 1, 8'd0, 1, 1);
      addVec("div0 back idle",   0, 16'd0, 8'd0, 0, 0, 0,  0, 0, 0, 8'd0, 1, 1);
      addVec("div5 cfg+start",   1, 16'd5, 8'd4, 0, 1, 0,  0, 0, 1, 8'd4, 1, 1);
      addVec("cfg during run",   1, 16'd2, 8'd1, 1, 0, 0,  0, 0, 1, 8'd4, 1, 3);
      addVec("div5 presc at 4",  0, 16'd0, 8'd0, 0, 0, 0,  0, 0, 1, 8'd4, 1, 1);
      addVec("stop at wrap",     0, 16'd0, 8'd0, 0, 0, 1,  0, 0, 0, 8'd4, 1, 1);
      addVec("idle holds",       0, 16'd0, 8'd0, 0, 0, 0,  0, 0, 0, 8'd4, 1, 2);
      addVec("stop in idle",     0, 16'd0, 8'd0, 0, 0, 1,  0, 0, 0, 8'd4, 1, 1);
      addVec("restart latched",  0, 16'd0, 8'd0, 0, 1, 0,  0, 0, 1, 8'd4, 1, 1);
      addVec("start in run",     0, 16'd0, 8'd0, 0, 1, 0,  0, 0, 1, 8'd4, 1, 4);
      addVec("div5 kept tick",   0, 16'd0, 8'd0, 0, 0, 0,  1, 0, 1, 8'd3, 0, 1);
      addVec("stop after tick",  0, 16'd0, 8'd0, 0, 0, 1,  0, 0, 0, 8'd3, 0, 1);

      doReset();

      foreach (vecs[i]) begin
         for (int r = 0; r < vecs[i].reps; r++) begin
            applyStimulus(vecs[i].cv, vecs[i].div, vecs[i].cnt, vecs[i].per,
                          vecs[i].st, vecs[i].sp);
            checkOutput(vecs[i].name, vecs[i].eTick, vecs[i].eDone, vecs[i].eBusy,
                        vecs[i].eRem, vecs[i].eClk);
         end
      end

      // Periodic div=3 count=2: tick every 3 cycles, done every 6, no gap.
      applyStimulus(1, 16'd3, 8'd2, 1, 1, 0);
      checkOutput("periodic start", 0, 0, 1, 8'd2, 0);
      lastRise = -1;
      rises    = 0;
      prevClk  = 0;
      for (int e = 1; e <= 24; e++) begin
         int n;
         bit et, ed;
         applyStimulus(0, 16'd0, 8'd0, 0, 0, 0);
         n  = e / 3;
         et = (e % 3 == 0);
         ed = et && (n % 2 == 0);
         checkOutput("periodic run", et, ed, 1, ed ? 8'd0 : 8'(2 - n % 2), bit'(n % 2));
         if (clk_out && !prevClk) begin
            if (lastRise >= 0) begin
               checks++;
               if (e - lastRise != 6) begin
                  failures++;
                  $display("[TB] FAIL clk_out period: got %0d cycles, expected 6", e - lastRise);
               end
            end
            lastRise = e;
            rises++;
         end
         prevClk = clk_out;
      end
      checks++;
      if (rises != 4) begin
         failures++;
         $display("[TB] FAIL clk_out rises: got %0d, expected 4", rises);
      end
      applyStimulus(0, 16'd0, 8'd0, 0, 0, 1);
      checkOutput("periodic stop", 0, 0, 0, 8'd0, 0);

      // Randomized traffic against the model.
      doReset();
      for (int k = 0; k < 3000; k++) begin
         rcv = ($urandom_range(0, 3) == 0);
         rd  = $urandom_range(0, 7);
         rc  = $urandom_range(0, 4);
         rp  = bit'($urandom_range(0, 1));
         rst = ($urandom_range(0, 5) == 0);
         rsp = ($urandom_range(0, 24) == 0);
         applyStimulus(rcv, 16'(rd), 8'(rc), rp, rst, rsp);
         modelStep(rcv, rd, rc, rp, rst, rsp);
         modelExpect(mt, md, mb, mr, mc);
         checkOutput("random", mt, md, mb, 8'(mr), mc);
      end

      // Reset between edges in the middle of a run, then the default config.
      applyStimulus(1, 16'd3, 8'd2, 1, 1, 0);
      repeat (4) applyStimulus(0, 16'd0, 8'd0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async reset immediate", 0, 0, 0, 8'd0, 0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset held", 0, 0, 0, 8'd0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 0; e < 10; e++) begin
         applyStimulus(0, 16'd0, 8'd0, 0, 0, 0);
         checkOutput("idle after reset", 0, 0, 0, 8'd0, 0);
      end
      applyStimulus(0, 16'd0, 8'd0, 0, 1, 0);
      checkOutput("default start", 0, 0, 1, 8'd1, 0);
      stray = 0;
      for (int e = 1; e <= 40000; e++) begin
         applyStimulus(0, 16'd0, 8'd0, 0, 0, 0);
         if (e == 20000) begin
            checkOutput("default tick1", 1, 1, 1, 8'd0, 1);
         end else if (e == 20001) begin
            checkOutput("default reload", 0, 0, 1, 8'd1, 1);
         end else if (e == 40000) begin
            checkOutput("default tick2", 1, 1, 1, 8'd0, 0);
         end else if (tick || done || !busy) begin
            stray++;
         end
      end
      checks++;
      if (stray != 0) begin
         failures++;
         $display("[TB] FAIL default run: got %0d off-schedule cycles, expected 0", stray);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
